// File: rtl/xh_chi_chn_merge.sv
// N-to-1 credit-based CHI channel merge: per-input FIFO and L-credit issuer, round-robin
// arbitration, registered output. Define XH_CHI_CHN_MERGE_SRCID_EN to stamp the source ID.
module xh_chi_chn_merge #(
  parameter int N_IN        = 4,
  parameter int FLIT_W      = 128,
  parameter int DEPTH       = 4,
  parameter int OUT_CRD_MAX = 15,
  parameter int SRCID_LSB   = 4,
  parameter int SRCID_W     = 7,
  parameter int SRCID_BASE  = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_IN-1:0]          in_flitv,
  input  logic [N_IN*FLIT_W-1:0]   in_flit,
  output logic [N_IN-1:0]          in_lcrdv,
  output logic                     out_flitv,
  output logic [FLIT_W-1:0]        out_flit,
  input  logic                     out_lcrdv,
  output logic [3:0]               out_crd_cnt,
  output logic                     err_ovf,
  output logic                     err_crd
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam int RR_W  = $clog2(N_IN);
  localparam int CRD_W = $clog2(OUT_CRD_MAX + 1);

  logic [FLIT_W-1:0] mem    [N_IN][DEPTH];
  logic [PTR_W-1:0]  wr_ptr [N_IN];
  logic [PTR_W-1:0]  rd_ptr [N_IN];
  logic [OCC_W-1:0]  occ    [N_IN];
  logic [OCC_W-1:0]  owed   [N_IN];
  logic [N_IN-1:0]   lcrdv_q;
  logic [RR_W-1:0]   rr_ptr;
  logic [CRD_W-1:0]  crd;
  logic              ovf_q;
  logic              crd_err_q;

  logic [N_IN-1:0]   full;
  logic [N_IN-1:0]   nonempty;
  logic [N_IN-1:0]   enq;
  logic [N_IN-1:0]   deq;
  logic              grant_p0;
  logic [RR_W-1:0]   win_p0;
  logic [FLIT_W-1:0] flit_p0;
  logic              vld_p1;
  logic [FLIT_W-1:0] flit_p1;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Saturating downstream credit count; simultaneous credit and send cancel out.
  function automatic logic [CRD_W-1:0] crd_next(input logic [CRD_W-1:0] c,
                                                input logic inc, input logic dec);
    if (inc && !dec) return (c == CRD_W'(OUT_CRD_MAX)) ? c : c + CRD_W'(1);
    if (dec && !inc) return c - CRD_W'(1);
    return c;
  endfunction

`ifdef XH_CHI_CHN_MERGE_SRCID_EN
  function automatic logic [SRCID_W-1:0] stamp_id(input logic [RR_W-1:0] w);
    return SRCID_W'(SRCID_BASE + int'(w));
  endfunction
`else
  logic srcid_unused;
  assign srcid_unused = ^{SRCID_LSB, SRCID_W, SRCID_BASE};
`endif

  always_comb begin
    full     = '0;
    nonempty = '0;
    enq      = '0;
    for (int i = 0; i < N_IN; i++) begin
      full[i]     = (occ[i] == OCC_W'(DEPTH));
      nonempty[i] = (occ[i] != '0);
      enq[i]      = in_flitv[i] && !full[i];
    end
  end

  // p0: round-robin grant from rr_ptr, gated by holding a downstream credit
  always_comb begin
    int idx;
    idx      = 0;
    grant_p0 = 1'b0;
    win_p0   = rr_ptr;
    deq      = '0;
    if (crd != '0) begin
      for (int k = 0; k < N_IN; k++) begin
        idx = int'(rr_ptr) + k;
        if (idx >= N_IN) idx = idx - N_IN;
        if (!grant_p0 && nonempty[idx]) begin
          grant_p0 = 1'b1;
          win_p0   = RR_W'(idx);
        end
      end
    end
    if (grant_p0) deq[win_p0] = 1'b1;
  end

  always_comb begin
    flit_p0 = mem[win_p0][rd_ptr[win_p0]];
`ifdef XH_CHI_CHN_MERGE_SRCID_EN
    flit_p0[SRCID_LSB +: SRCID_W] = stamp_id(win_p0);
`endif
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < N_IN; i++) begin
      if (enq[i]) mem[i][wr_ptr[i]] <= in_flit[i*FLIT_W +: FLIT_W];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < N_IN; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        occ[i]    <= '0;
        owed[i]   <= OCC_W'(DEPTH);
      end
      lcrdv_q   <= '0;
      rr_ptr    <= '0;
      crd       <= '0;
      ovf_q     <= 1'b0;
      crd_err_q <= 1'b0;
      vld_p1    <= 1'b0;
      flit_p1   <= '0;
    end else begin
      for (int i = 0; i < N_IN; i++) begin
        if (enq[i]) wr_ptr[i] <= ptr_inc(wr_ptr[i]);
        if (deq[i]) rd_ptr[i] <= ptr_inc(rd_ptr[i]);
        occ[i]     <= occ[i] + OCC_W'(enq[i]) - OCC_W'(deq[i]);
        lcrdv_q[i] <= (owed[i] != '0);
        owed[i]    <= owed[i] - OCC_W'(owed[i] != '0) + OCC_W'(deq[i]);
      end
      if (|(in_flitv & full)) ovf_q <= 1'b1;
      if (out_lcrdv && !grant_p0 && crd == CRD_W'(OUT_CRD_MAX)) crd_err_q <= 1'b1;
      crd <= crd_next(crd, out_lcrdv, grant_p0);
      if (grant_p0) rr_ptr <= (win_p0 == RR_W'(N_IN - 1)) ? '0 : win_p0 + RR_W'(1);
      // p1: registered output pulse; flit holds between grants
      vld_p1 <= grant_p0;
      if (grant_p0) flit_p1 <= flit_p0;
    end
  end

  assign in_lcrdv    = lcrdv_q;
  assign out_flitv   = vld_p1;
  assign out_flit    = flit_p1;
  assign out_crd_cnt = 4'(crd);
  assign err_ovf     = ovf_q;
  assign err_crd     = crd_err_q;

endmodule

// File: tb/tb_xh_chi_chn_merge.sv
// Bench for xh_chi_chn_merge: vector table for single transfers, hand sequences for
// credit init, gating, fairness, overflow, saturation, reset and source-ID stamping.
module tb_xh_chi_chn_merge;
  localparam int N_IN = 4;
  localparam int FW   = 128;
`ifdef XH_CHI_CHN_MERGE_SRCID_EN
  localparam bit SRCID_EN = 1'b1;
`else
  localparam bit SRCID_EN = 1'b0;
`endif

  logic              clk;
  logic              rst_n;
  logic [N_IN-1:0]   in_flitv;
  logic [N_IN*FW-1:0] in_flit;
  logic [N_IN-1:0]   in_lcrdv;
  logic              out_flitv;
  logic [FW-1:0]     out_flit;
  logic              out_lcrdv;
  logic [3:0]        out_crd_cnt;
  logic              err_ovf;
  logic              err_crd;

  xh_chi_chn_merge #(
    .N_IN(N_IN), .FLIT_W(FW), .DEPTH(4), .OUT_CRD_MAX(15),
    .SRCID_LSB(4), .SRCID_W(7), .SRCID_BASE(32'h20)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_flitv(in_flitv), .in_flit(in_flit),
    .in_lcrdv(in_lcrdv), .out_flitv(out_flitv), .out_flit(out_flit),
    .out_lcrdv(out_lcrdv), .out_crd_cnt(out_crd_cnt),
    .err_ovf(err_ovf), .err_crd(err_crd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int out_cnt = 0;
  logic [FW-1:0] sb[$];
  logic [FW-1:0] mon_exp;

  typedef struct {
    int            port;
    logic [FW-1:0] data;
    logic [FW-1:0] expv;
  } vec_t;
  vec_t tbl[6];

  task automatic chk(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [FW-1:0] exp_flit(input int port, input logic [FW-1:0] d);
    logic [FW-1:0] r;
    logic [6:0]    id;
    r  = d;
    id = 7'(32'h20 + port);
    r[10:4] = SRCID_EN ? id : d[10:4];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int port, input logic [FW-1:0] d);
    in_flitv[port] = 1'b1;
    in_flit[port*FW +: FW] = d;
  endtask

  task automatic do_reset();
    in_flitv = '0;
    out_lcrdv = 1'b0;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Scoreboard: every output flit must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && out_flitv) begin
      out_cnt++;
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected: got %0h expected no flit", out_flit);
      end else begin
        mon_exp = sb.pop_front();
        chk("sb_flit", out_flit, mon_exp);
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    in_flitv = '0;
    in_flit = '0;
    out_lcrdv = 1'b0;
    tbl[0] = '{0, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, '0};
    tbl[1] = '{1, 128'h0, '0};
    tbl[2] = '{2, 128'hAAAA_5555_AAAA_5555_AAAA_5555_AAAA_5555, '0};
    tbl[3] = '{0, 128'h8000_0000_0000_0000_0000_0000_0000_0001, '0};
    tbl[4] = '{1, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, '0};
    tbl[5] = '{3, 128'h5555_AAAA_5555_AAAA_5555_AAAA_5555_AAAA, '0};
    for (int i = 0; i < 6; i++) tbl[i].expv = exp_flit(tbl[i].port, tbl[i].data);

    // reset state
    tick();
    tick();
    chk("rst_lcrdv", 128'(in_lcrdv), 0);
    chk("rst_flitv", 128'(out_flitv), 0);
    chk("rst_flit", out_flit, 0);
    chk("rst_crd", 128'(out_crd_cnt), 0);
    chk("rst_errs", 128'({err_ovf, err_crd}), 0);
    rst_n = 1'b1;

    // credit init: DEPTH pulses on every input, then silence
    for (int c = 1; c <= 6; c++) begin
      tick();
      chk("lcrd_init", 128'(in_lcrdv), (c <= 4) ? 128'hF : 128'h0);
      chk("init_flitv", 128'(out_flitv), 0);
    end

    // credit-gated send on input 2
    drive(2, 128'hA5);
    sb.push_back(exp_flit(2, 128'hA5));
    tick();
    in_flitv = '0;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("gate_noflit", 128'(out_flitv), 0);
    end
    out_lcrdv = 1'b1;
    tick();
    out_lcrdv = 1'b0;
    chk("gate_lat1", 128'(out_flitv), 0);
    tick();
    chk("gate_flitv", 128'(out_flitv), 1);
    chk("gate_flit", out_flit, exp_flit(2, 128'hA5));
    tick();
    chk("gate_lcrdv", 128'(in_lcrdv), 128'h4);
    chk("gate_pulse", 128'(out_flitv), 0);
    chk("gate_crd", 128'(out_crd_cnt), 0);
    tick();
    chk("gate_lcrdv_end", 128'(in_lcrdv), 0);

    // vector table: single transfers with credit available
    out_lcrdv = 1'b1;
    repeat (10) tick();
    out_lcrdv = 1'b0;
    chk("tbl_crd0", 128'(out_crd_cnt), 10);
    for (int i = 0; i < 6; i++) begin
      drive(tbl[i].port, tbl[i].data);
      sb.push_back(tbl[i].expv);
      tick();
      in_flitv = '0;
      chk("tbl_lat1", 128'(out_flitv), 0);
      tick();
      chk("tbl_flitv", 128'(out_flitv), 1);
      chk("tbl_flit", out_flit, tbl[i].expv);
      tick();
      chk("tbl_pulse", 128'(out_flitv), 0);
      chk("tbl_hold", out_flit, tbl[i].expv);
    end
    chk("tbl_crd1", 128'(out_crd_cnt), 4);

    // fairness: 15 credits, two flits on every input
    out_lcrdv = 1'b1;
    repeat (11) tick();
    out_lcrdv = 1'b0;
    chk("fair_crd", 128'(out_crd_cnt), 15);
    chk("fair_errcrd", 128'(err_crd), 0);
    for (int r = 0; r < 2; r++)
      for (int p = 0; p < N_IN; p++) sb.push_back(exp_flit(p, 128'(p * 256 + r + 32'h1000)));
    for (int p = 0; p < N_IN; p++) drive(p, 128'(p * 256 + 32'h1000));
    tick();
    for (int p = 0; p < N_IN; p++) drive(p, 128'(p * 256 + 1 + 32'h1000));
    tick();
    in_flitv = '0;
    chk("fair_b2b", 128'(out_flitv), 1);
    for (int c = 0; c < 7; c++) begin
      tick();
      chk("fair_b2b", 128'(out_flitv), 1);
    end
    tick();
    chk("fair_end", 128'(out_flitv), 0);
    chk("fair_crd_end", 128'(out_crd_cnt), 7);

    // overflow on input 1 with no downstream credit
    do_reset();
    repeat (6) tick();
    chk("ovf_crd0", 128'(out_crd_cnt), 0);
    for (int k = 0; k < 4; k++) begin
      drive(1, 128'(32'hB00 + k));
      sb.push_back(exp_flit(1, 128'(32'hB00 + k)));
      tick();
    end
    chk("ovf_not_yet", 128'(err_ovf), 0);
    drive(1, 128'(32'hB04));
    tick();
    in_flitv = '0;
    chk("ovf_set", 128'(err_ovf), 1);
    chk("ovf_held", 128'(out_flitv), 0);
    begin
      int base;
      base = out_cnt;
      out_lcrdv = 1'b1;
      repeat (6) tick();
      out_lcrdv = 1'b0;
      repeat (3) tick();
      chk("ovf_drain", 128'(out_cnt - base), 4);
    end
    chk("ovf_crd", 128'(out_crd_cnt), 2);
    chk("ovf_sticky", 128'(err_ovf), 1);

    // credit saturation
    do_reset();
    chk("sat_clr_ovf", 128'(err_ovf), 0);
    out_lcrdv = 1'b1;
    repeat (15) tick();
    chk("sat_crd15", 128'(out_crd_cnt), 15);
    chk("sat_noerr", 128'(err_crd), 0);
    tick();
    out_lcrdv = 1'b0;
    chk("sat_crd16", 128'(out_crd_cnt), 15);
    chk("sat_err", 128'(err_crd), 1);
    drive(0, 128'hC0FFEE00);
    sb.push_back(exp_flit(0, 128'hC0FFEE00));
    tick();
    in_flitv = '0;
    out_lcrdv = 1'b1;
    tick();
    out_lcrdv = 1'b0;
    chk("sat_send", 128'(out_flitv), 1);
    chk("sat_cancel", 128'(out_crd_cnt), 15);
    tick();

    // reset while flits are buffered discards them and clears sticky errors
    for (int p = 0; p < N_IN; p++) drive(p, 128'(32'hD00 + p));
    tick();
    in_flitv = '0;
    rst_n = 1'b0;
    tick();
    chk("mid_rst_flitv", 128'(out_flitv), 0);
    tick();
    rst_n = 1'b1;
    chk("mid_rst_errcrd", 128'(err_crd), 0);
    chk("mid_rst_crd", 128'(out_crd_cnt), 0);
    out_lcrdv = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("mid_rst_empty", 128'(out_flitv), 0);
    end
    out_lcrdv = 1'b0;
    tick();
    chk("mid_rst_empty", 128'(out_flitv), 0);

    // source-ID stamping on input 3
    drive(3, 128'h0);
    sb.push_back(exp_flit(3, 128'h0));
    tick();
    in_flitv = '0;
    tick();
    chk("srcid_flitv", 128'(out_flitv), 1);
    chk("srcid_flit", out_flit, SRCID_EN ? 128'h230 : 128'h0);
    repeat (3) tick();

    chk("sb_empty", 128'(sb.size()), 0);
    chk("out_total", 128'(out_cnt), 21);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
